// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline stall/bubble/flush sequencing with a shadow
//            scoreboard and registered EX forwarding selects.
// Option   : HAZARD_PERF_EN adds stall-cycle and redirect counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int FWD_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic             d_srca_r,
    input  logic             d_srcb_r,
    input  logic [REG_W-1:0] d_dst,
    input  logic             d_regwrite,
    input  logic             d_memread,
    input  logic             e_redirect,
    input  logic             i_busy,
    input  logic             d_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             bubble_e,
    output logic             bubble_w,
    output logic             flush_d,
    output logic             drop_fetch,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic [REG_W-1:0] dst;
    } sb_entry_t;

    localparam logic [0:0]       c_idle   = 1'b0;
    localparam logic [0:0]       c_drop   = 1'b1;
    localparam logic [FWD_W-1:0] c_fwd_rf = FWD_W'(0);
    localparam logic [FWD_W-1:0] c_fwd_m  = FWD_W'(1);
    localparam logic [FWD_W-1:0] c_fwd_w  = FWD_W'(2);

    logic [0:0]       state_q, state_d;
    sb_entry_t        sb_e_q, sb_e_d;
    sb_entry_t        sb_m_q, sb_m_d;
    logic             e_memread_q, e_memread_d;
    logic [FWD_W-1:0] fwd_a_q, fwd_a_d;
    logic [FWD_W-1:0] fwd_b_q, fwd_b_d;

    logic w_hit_e_a, w_hit_e_b, w_hit_m_a, w_hit_m_b;
    logic w_redirect, w_load_use;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_bubble_e, w_bubble_w, w_flush_d, w_drop_fetch;

    function automatic logic src_hit(input logic             rd,
                                     input logic [REG_W-1:0] idx,
                                     input sb_entry_t        ent);
        return rd && (idx != '0) && ent.valid && ent.regwrite && (ent.dst == idx);
    endfunction

    assign w_hit_e_a = src_hit(d_srca_r, d_rs1, sb_e_q);
    assign w_hit_e_b = src_hit(d_srcb_r, d_rs2, sb_e_q);
    assign w_hit_m_a = src_hit(d_srca_r, d_rs1, sb_m_q);
    assign w_hit_m_b = src_hit(d_srcb_r, d_rs2, sb_m_q);

    // A pending memory wait freezes the whole back end, so redirect and
    // load-use are only honoured once it clears.
    assign w_redirect = e_redirect && !d_busy;
    assign w_load_use = d_valid && e_memread_q && (w_hit_e_a || w_hit_e_b)
                        && !e_redirect && !d_busy;

    always_comb begin
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_stall_m  = 1'b0;
        w_bubble_e = 1'b0;
        w_bubble_w = 1'b0;
        w_flush_d  = 1'b0;
        if (d_busy) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_stall_e  = 1'b1;
            w_stall_m  = 1'b1;
            w_bubble_w = 1'b1;
        end else if (w_redirect) begin
            w_flush_d  = 1'b1;
            w_bubble_e = 1'b1;
        end else if (w_load_use) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_bubble_e = 1'b1;
        end else if ((state_q == c_drop) || i_busy) begin
            w_stall_f  = 1'b1;
            w_flush_d  = 1'b1;
        end
    end

    assign w_drop_fetch = (state_q == c_drop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (w_redirect && i_busy) state_d = c_drop;
            c_drop:  if (!w_redirect && !i_busy) state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        sb_m_d = d_busy ? sb_m_q : sb_e_q;
        if (d_busy) begin
            sb_e_d      = sb_e_q;
            e_memread_d = e_memread_q;
            fwd_a_d     = fwd_a_q;
            fwd_b_d     = fwd_b_q;
        end else if (w_bubble_e) begin
            sb_e_d      = '0;
            e_memread_d = 1'b0;
            fwd_a_d     = c_fwd_rf;
            fwd_b_d     = c_fwd_rf;
        end else begin
            sb_e_d.valid    = d_valid;
            sb_e_d.regwrite = d_regwrite;
            sb_e_d.dst      = d_dst;
            e_memread_d     = d_valid && d_memread;
            // Producer one ahead (now in E) is the most recent writer, so it wins.
            fwd_a_d = w_hit_e_a ? c_fwd_m : (w_hit_m_a ? c_fwd_w : c_fwd_rf);
            fwd_b_d = w_hit_e_b ? c_fwd_m : (w_hit_m_b ? c_fwd_w : c_fwd_rf);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= c_idle;
            sb_e_q      <= '0;
            sb_m_q      <= '0;
            e_memread_q <= 1'b0;
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            sb_e_q      <= sb_e_d;
            sb_m_q      <= sb_m_d;
            e_memread_q <= e_memread_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign stall_f    = resetn && w_stall_f;
    assign stall_d    = resetn && w_stall_d;
    assign stall_e    = resetn && w_stall_e;
    assign stall_m    = resetn && w_stall_m;
    assign bubble_e   = resetn && w_bubble_e;
    assign bubble_w   = resetn && w_bubble_w;
    assign flush_d    = resetn && w_flush_d;
    assign drop_fetch = resetn && w_drop_fetch;
    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, w_stall_d};
        perf_flush_d = perf_flush_q + {31'd0, w_redirect};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Default build carries no performance counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed plan scenarios plus randomized traffic against an
//            instruction-level pipeline model of hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       d_valid, d_srca_r, d_srcb_r, d_regwrite, d_memread;
    logic [4:0] d_rs1, d_rs2, d_dst;
    logic       e_redirect, i_busy, d_busy;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       bubble_e, bubble_w, flush_d, drop_fetch;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_W(5), .FWD_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_srca_r(d_srca_r), .d_srcb_r(d_srcb_r), .d_dst(d_dst),
        .d_regwrite(d_regwrite), .d_memread(d_memread),
        .e_redirect(e_redirect), .i_busy(i_busy), .d_busy(d_busy),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_e(bubble_e), .bubble_w(bubble_w), .flush_d(flush_d),
        .drop_fetch(drop_fetch), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w, flush_d, drop_fetch, fwd_a, fwd_b}
    logic [11:0] obs;
    assign obs = {stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w,
                  flush_d, drop_fetch, fwd_a, fwd_b};

    // Instruction-level model: what sits in EX and MEM, and whether a stale fetch is owed.
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic [1:0] fa;
        logic [1:0] fb;
    } instr_t;

    instr_t      ex_i, mem_i;
    logic        in_drop;
    int unsigned m_stall_cnt, m_flush_cnt;

    function automatic logic [11:0] mk(input logic sf, sd, se, sm, be, bw, fd, dr,
                                       input logic [1:0] fa, fb);
        return {sf, sd, se, sm, be, bw, fd, dr, fa, fb};
    endfunction

    function automatic logic produces(input instr_t s, input logic rd, input logic [4:0] idx);
        return rd && (idx != 5'd0) && s.v && s.rw && (s.dst == idx);
    endfunction

    function automatic logic [1:0] sel(input logic rd, input logic [4:0] idx);
        if (produces(ex_i, rd, idx)) return 2'd1;
        if (produces(mem_i, rd, idx)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic load_use_m();
        return d_valid && ex_i.v && ex_i.mr && !e_redirect &&
               (produces(ex_i, d_srca_r, d_rs1) || produces(ex_i, d_srcb_r, d_rs2));
    endfunction

    function automatic logic [11:0] model_outs();
        logic [11:0] o;
        if (!resetn) return 12'd0;
        if (d_busy)                o = mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        else if (e_redirect)       o = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        else if (load_use_m())     o = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        else if (in_drop || i_busy) o = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        else                       o = 12'd0;
        o[4]   = in_drop;
        o[3:2] = ex_i.fa;
        o[1:0] = ex_i.fb;
        return o;
    endfunction

    task automatic model_reset();
        ex_i = '0;
        mem_i = '0;
        in_drop = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic tick();
        logic [11:0] e;
        instr_t      nx;
        logic        taken, lu;
        e     = model_outs();
        taken = resetn && e_redirect && !d_busy;
        lu    = load_use_m();
        nx.v  = d_valid;
        nx.dst = d_dst;
        nx.rw = d_regwrite;
        nx.mr = d_memread;
        nx.fa = sel(d_srca_r, d_rs1);
        nx.fb = sel(d_srcb_r, d_rs2);
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            if (e[10]) m_stall_cnt++;
            if (taken) m_flush_cnt++;
            in_drop = in_drop ? (taken || i_busy) : (taken && i_busy);
            if (!d_busy) begin
                mem_i = ex_i;
                ex_i  = (taken || lu) ? instr_t'(0) : nx;
            end
        end
        @(negedge clk);
    endtask

    task automatic clr_in();
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_srca_r = 0; d_srcb_r = 0;
        d_dst = 0; d_regwrite = 0; d_memread = 0;
        e_redirect = 0; i_busy = 0; d_busy = 0;
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs1, rs2, input logic ra, rb,
                         input logic [4:0] dst, input logic rw, mr);
        d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_srca_r = ra; d_srcb_r = rb;
        d_dst = dst; d_regwrite = rw; d_memread = mr;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        clr_in();
        d_busy = 1; i_busy = 1; e_redirect = 1;
        #1;
        exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, exp); end
        checks++;
        clr_in();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        model_reset();
        #1;
        if (obs !== exp) begin errors++; $display("FAIL post_reset_idle: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_load_use();
        logic [11:0] exp;
        clr_in();
        set_d(1, 0, 0, 0, 0, 5, 1, 1);
        #1; tick();
        set_d(1, 5, 1, 1, 1, 6, 1, 0);
        #1; exp = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        if (obs !== exp) begin errors++; $display("FAIL load_use_stall: got %b want %b", obs, exp); end
        checks++;
        tick();
        #1; exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL load_use_release: got %b want %b", obs, exp); end
        checks++;
        tick();
        clr_in();
        #1; exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        if (obs !== exp) begin errors++; $display("FAIL load_use_fwd_w: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_fwd_alu();
        logic [11:0] exp;
        set_d(1, 0, 0, 0, 0, 3, 1, 0);
        #1; exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL alu_issue: got %b want %b", obs, exp); end
        checks++;
        tick();
        set_d(1, 3, 3, 1, 1, 4, 1, 0);
        #1;
        if (obs !== exp) begin errors++; $display("FAIL alu_dep_nostall: got %b want %b", obs, exp); end
        checks++;
        tick();
        clr_in();
        #1; exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (obs !== exp) begin errors++; $display("FAIL alu_fwd_m: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_x0();
        logic [11:0] exp;
        exp = 12'd0;
        set_d(1, 0, 0, 0, 0, 0, 0, 1);
        #1;
        if (obs !== exp) begin errors++; $display("FAIL x0_write: got %b want %b", obs, exp); end
        checks++;
        tick();
        set_d(1, 0, 0, 1, 1, 7, 1, 0);
        #1;
        if (obs !== exp) begin errors++; $display("FAIL x0_read_nostall: got %b want %b", obs, exp); end
        checks++;
        tick();
        clr_in();
        #1;
        if (obs !== exp) begin errors++; $display("FAIL x0_fwd_zero: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_redirect_drop();
        logic [11:0] exp;
        clr_in();
        e_redirect = 1; i_busy = 1;
        #1; exp = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        if (obs !== exp) begin errors++; $display("FAIL redirect_flush: got %b want %b", obs, exp); end
        checks++;
        tick();
        e_redirect = 0;
        for (int k = 0; k < 3; k++) begin
            i_busy = (k < 2);
            #1; exp = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            if (obs !== exp) begin errors++; $display("FAIL drop_cycle%0d: got %b want %b", k, obs, exp); end
            checks++;
            tick();
        end
        #1; exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL drop_exit: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_dbusy();
        logic [11:0] exp;
        clr_in();
        set_d(1, 0, 0, 0, 0, 5, 1, 1);
        #1; tick();
        set_d(1, 5, 1, 1, 1, 6, 1, 0);
        e_redirect = 1; d_busy = 1;
        for (int k = 0; k < 4; k++) begin
            #1; exp = mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
            if (obs !== exp) begin errors++; $display("FAIL dbusy_hold%0d: got %b want %b", k, obs, exp); end
            checks++;
            tick();
        end
        d_busy = 0;
        #1; exp = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        if (obs !== exp) begin errors++; $display("FAIL dbusy_redirect_taken: got %b want %b", obs, exp); end
        checks++;
        tick();
        clr_in();
        #1; exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL dbusy_after: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_async_reset();
        logic [11:0] exp;
        clr_in();
        e_redirect = 1; i_busy = 1;
        #1; tick();
        e_redirect = 0;
        set_d(1, 0, 0, 0, 0, 3, 1, 0);
        #1; tick();
        set_d(1, 3, 0, 1, 0, 4, 1, 0);
        #1; tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        d_busy = 1;
        #1; exp = mk(1, 1, 1, 1, 0, 1, 0, 1, 1, 0);
        if (obs !== exp) begin errors++; $display("FAIL stall_before_reset: got %b want %b", obs, exp); end
        checks++;
        #2;
        resetn = 0;
        model_reset();
        #1; exp = 12'd0;
        if (obs !== exp) begin errors++; $display("FAIL async_reset: got %b want %b", obs, exp); end
        checks++;
        tick();
        clr_in();
        resetn = 1;
        i_busy = 1;
        #1; exp = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        if (obs !== exp) begin errors++; $display("FAIL idle_after_reset: got %b want %b", obs, exp); end
        checks++;
        tick();
    endtask

    task automatic test_random();
        logic [11:0] exp;
        for (int n = 0; n < 800; n++) begin
            d_valid    = ($urandom_range(0, 3) != 0);
            d_rs1      = 5'($urandom_range(0, 3));
            d_rs2      = 5'($urandom_range(0, 3));
            d_srca_r   = 1'($urandom_range(0, 1));
            d_srcb_r   = 1'($urandom_range(0, 1));
            d_dst      = 5'($urandom_range(0, 3));
            d_regwrite = d_valid && (d_dst != 5'd0) && ($urandom_range(0, 3) != 0);
            d_memread  = d_valid && ($urandom_range(0, 2) == 0);
            e_redirect = ($urandom_range(0, 9) == 0);
            i_busy     = ($urandom_range(0, 3) == 0);
            d_busy     = ($urandom_range(0, 7) == 0);
            #1; exp = model_outs();
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", n, obs, exp);
            end
            checks++;
            tick();
        end
`ifdef HAZARD_PERF_EN
        if (perf_stall_cnt !== m_stall_cnt) begin
            errors++;
            $display("FAIL perf_stall_cnt: got %0d want %0d", perf_stall_cnt, m_stall_cnt);
        end
        checks++;
        if (perf_flush_cnt !== m_flush_cnt) begin
            errors++;
            $display("FAIL perf_flush_cnt: got %0d want %0d", perf_flush_cnt, m_flush_cnt);
        end
        checks++;
`endif
        clr_in();
    endtask

    initial begin
        model_reset();
        clr_in();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_fwd_alu();
        test_x0();
        test_redirect_drop();
        test_dbusy();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (F/D/E/M/W).
- Consumes the decode-stage control bundle (register sources, destination, regwrite, memread), EX-stage redirects and memory busy flags.
- Produces per-stage stall, bubble and flush controls, plus registered operand-forwarding selects for EX.
- Keeps its own shadow scoreboard of the destinations in flight in E, M and W, so the datapath pipeline registers need not be inspected.

Parameters:
REG_W, 5, register index width
FWD_W, 2, forwarding select width

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
d_valid  in  1  D holds a valid instruction
d_rs1  in  REG_W  D source A index
d_rs2  in  REG_W  D source B index
d_srca_r  in  1  D reads rs1
d_srcb_r  in  1  D reads rs2
d_dst  in  REG_W  D destination index
d_regwrite  in  1  D writes a register (already 0 for x0)
d_memread  in  1  D is a load
e_redirect  in  1  EX resolved jump or taken branch
i_busy  in  1  fetch request outstanding
d_busy  in  1  data-memory access in M not complete
stall_f  out  1  hold PC/F
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M register
bubble_e  out  1  load NOP into D/E
bubble_w  out  1  load NOP into M/W
flush_d  out  1  load NOP into F/D
drop_fetch  out  1  discard the returning fetch data
fwd_a  out  FWD_W  EX source A select: 0 regfile, 1 from M, 2 from W
fwd_b  out  FWD_W  EX source B select, same encoding

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low (resetn).
- While resetn=0: all outputs 0, scoreboard entries (valid, dst, regwrite, memread for E, M, W) cleared, FSM in IDLE.

Scoreboard advance (posedge):
- If d_busy: E and M entries hold, W entry cleared.
- Else: W<=M, M<=E.
- E entry: loaded from D when D advances; cleared when bubble_e.

Hazard matching:
- A source hits a stage when its read flag=1, index != 0, the stage entry is valid with regwrite=1, and dst equals the index.

Load-use:
- Condition: d_valid, E entry memread=1, either source hits E, no redirect.
- Response: stall_f=stall_d=1 and bubble_e=1 for exactly one cycle.
- The following cycle the load is in M and forwarding resolves the hazard.

Data-memory wait:
- d_busy=1 gives stall_f=stall_d=stall_e=stall_m=1 and bubble_w=1.
- Load-use and redirect evaluation is suppressed during d_busy; they are re-evaluated the first cycle d_busy=0.

Fetch wait:
- i_busy=1 (FSM in IDLE) gives stall_f=1 and flush_d=1 (bubble into D); later stages keep flowing.

Redirect (e_redirect=1, d_busy=0):
- flush_d=1 and bubble_e=1 in the same cycle; stall_f forced 0 so the PC loads the target.
- Redirect overrides a simultaneous load-use stall.
- If i_busy=1 in that cycle, the FSM goes IDLE->DROP.

FSM DROP state:
- drop_fetch=1, flush_d=1, stall_f=1.
- Exits to IDLE on the first cycle i_busy=0; that cycle's returned word is dropped.
- A second redirect while in DROP stays in DROP.

Forwarding selects:
- Computed from D's sources against the E entry (giving select 1) and the M entry (giving select 2); E takes priority when both hit.
- Registered into fwd_a/fwd_b when D advances.
- Forced to 0 on bubble_e; held under stall_e.
- Latency one cycle: the selects are valid while the instruction occupies EX.

Priority, high to low:
1. reset
2. d_busy
3. redirect
4. load-use
5. i_busy

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with stall_d=1) and perf_flush_cnt[31:0] (redirects accepted).
- Both counters clear on reset and wrap 0xFFFFFFFF->0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load x5 in E, D has add x6,x5,x1 with srca_r=1 -> one cycle of stall_f=stall_d=bubble_e=1; next EX cycle fwd_a=2 (W, load result), fwd_b=0.
2. addi x3 in E, then add x4,x3,x3 in D -> no stall; fwd_a=fwd_b=1 registered on the next edge.
3. D writes x0 (d_regwrite=0) followed by a reader of x0 -> no stall; fwd selects remain 0.
4. e_redirect=1 with i_busy=1 held for 3 cycles -> flush_d and bubble_e in the redirect cycle; drop_fetch=1 for 3 cycles, back to IDLE when i_busy falls.
5. d_busy=1 for 4 cycles concurrent with load-use and e_redirect -> stall_f/d/e/m=1 and bubble_w=1 for 4 cycles, no flush; the redirect is taken on cycle 5.
6. Assert resetn=0 mid-stall with fwd_a=1 -> all outputs 0 immediately (asynchronous), FSM back in IDLE.
